// File: rtl/umem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : umem_arb_pkg
// Brief   : Shared types for the unified-memory arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package umem_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        FORCE  = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_CORE   = 1'b0,
        GNT_LOADER = 1'b1
    } gnt_e;

    typedef struct packed {
        logic valid;
        logic is_read;
    } rsp_pipe_t;

endpackage

`default_nettype wire

// File: rtl/umem_rr_pick.sv
//------------------------------------------------------------------------------
// Module  : umem_rr_pick
// Brief   : Two-way round-robin picker; mask[0]=core, mask[1]=loader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module umem_rr_pick
    import umem_arb_pkg::*;
(
    input  logic       i_core_valid,
    input  logic       i_ld_valid,
    input  gnt_e       i_last_grant,
    input  logic [1:0] i_mask,
    output logic       o_gnt_core,
    output logic       o_gnt_ld
);

    logic w_core_ok;
    logic w_ld_ok;

    assign w_core_ok = i_core_valid & i_mask[0];
    assign w_ld_ok   = i_ld_valid   & i_mask[1];

    // On a tie the core wins only if the loader was served last.
    assign o_gnt_core = w_core_ok & (~w_ld_ok | (i_last_grant == GNT_LOADER));
    assign o_gnt_ld   = w_ld_ok & ~o_gnt_core;

endmodule

`default_nettype wire

// File: rtl/umem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : umem_arbiter
// Brief   : Round-robin arbiter with loader lock for the single-ported umem.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module umem_arbiter
    import umem_arb_pkg::*;
#(
    parameter int AW       = 9,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req_valid,
    output logic          core_req_ready,
    input  logic          core_req_rw,
    input  logic [AW-1:0] core_req_addr,
    input  logic [DW-1:0] core_req_wdata,
    output logic          core_rsp_valid,
    output logic [DW-1:0] core_rsp_rdata,
    input  logic          ld_req_valid,
    output logic          ld_req_ready,
    input  logic [AW-1:0] ld_req_addr,
    input  logic [DW-1:0] ld_req_wdata,
    input  logic          ld_lock,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int              c_CW  = $clog2(MAX_LOCK + 1);
    localparam logic [c_CW-1:0] c_MAX = c_CW'(MAX_LOCK);
    localparam logic [c_CW-1:0] c_ONE = c_CW'(1);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    gnt_e            r_last_grant;
    logic [c_CW-1:0] r_lock_cnt;
    logic [c_CW-1:0] w_lock_cnt_nxt;
    logic [1:0]      w_mask;
    logic            w_gnt_core;
    logic            w_gnt_ld;
    rsp_pipe_t       r_pipe1;
    rsp_pipe_t       r_pipe2;
    logic            r_mem_en;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    // Nobody is eligible while reset is asserted so ready stays low.
    always_comb begin
        w_mask = 2'b11;
        if (reset) begin
            w_mask = 2'b00;
        end else begin
            case (r_state)
                LOCKED:  if (ld_lock) w_mask = 2'b10;
                FORCE:   w_mask = 2'b01;
                default: w_mask = 2'b11;
            endcase
        end
    end

    umem_rr_pick u_pick (
        .i_core_valid (core_req_valid),
        .i_ld_valid   (ld_req_valid),
        .i_last_grant (r_last_grant),
        .i_mask       (w_mask),
        .o_gnt_core   (w_gnt_core),
        .o_gnt_ld     (w_gnt_ld)
    );

    assign core_req_ready = w_gnt_core;
    assign ld_req_ready   = w_gnt_ld;

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ARB: begin
                if (w_gnt_ld && ld_lock) begin
                    w_state_nxt    = LOCKED;
                    w_lock_cnt_nxt = c_ONE;
                end
            end
            LOCKED: begin
                if (!ld_lock) begin
                    w_state_nxt = ARB;
                end else begin
                    if (w_gnt_ld && (r_lock_cnt != c_MAX)) w_lock_cnt_nxt = r_lock_cnt + c_ONE;
                    if ((r_lock_cnt == c_MAX) && core_req_valid) w_state_nxt = FORCE;
                end
            end
            FORCE: begin
                w_lock_cnt_nxt = '0;
                w_state_nxt    = (w_gnt_core && ld_lock) ? LOCKED : ARB;
            end
            default: begin
                w_state_nxt    = ARB;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ARB;
            r_last_grant <= GNT_LOADER;
            r_lock_cnt   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_pipe1      <= '0;
            r_pipe2      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt_core)    r_last_grant <= GNT_CORE;
            else if (w_gnt_ld) r_last_grant <= GNT_LOADER;
            r_mem_en <= w_gnt_core | w_gnt_ld;
            r_mem_we <= w_gnt_core ? core_req_rw : w_gnt_ld;
            if (w_gnt_core) begin
                r_mem_addr  <= core_req_addr;
                r_mem_wdata <= core_req_wdata;
            end else if (w_gnt_ld) begin
                r_mem_addr  <= ld_req_addr;
                r_mem_wdata <= ld_req_wdata;
            end
            r_pipe1.valid   <= w_gnt_core;
            r_pipe1.is_read <= w_gnt_core & ~core_req_rw;
            r_pipe2         <= r_pipe1;
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // Sync-read data lands in the same cycle the response stage is valid.
    assign core_rsp_valid = r_pipe2.valid;
    assign core_rsp_rdata = r_pipe2.is_read ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_umem_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_umem_arbiter
// Brief   : Randomized self-checking bench for umem_arbiter against a
//           transaction-level model with a shadow memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_umem_arbiter;

    localparam int AW       = 9;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req_valid, core_req_ready, core_req_rw;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata;
    logic          core_rsp_valid;
    logic [DW-1:0] core_rsp_rdata;
    logic          ld_req_valid, ld_req_ready, ld_lock;
    logic [AW-1:0] ld_req_addr;
    logic [DW-1:0] ld_req_wdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    umem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
        .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
        .core_rsp_rdata(core_rsp_rdata), .ld_req_valid(ld_req_valid),
        .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
        .ld_req_wdata(ld_req_wdata), .ld_lock(ld_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory attached to the arbiter.
    bit [DW-1:0]   mem_arr [0:(1<<AW)-1];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_data;
    always @(posedge clk) begin
        if (poke_en) mem_arr[poke_addr] <= poke_data;
        else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    // Reference model: who may be served, how long the loader has held the
    // memory, and the expected memory operation / response timeline.
    typedef struct { int due; logic [DW-1:0] data; } rsp_t;
    rsp_t          rq[$];
    bit [DW-1:0]   shadow [0:(1<<AW)-1];
    bit            m_last_core, m_locked, m_force;
    int            m_streak;
    bit            e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    int            cyc = 0;

    // Pending (not yet accepted) requests of the random driver.
    bit            d_cv, d_crw, d_lv;
    logic [AW-1:0] d_ca, d_la;
    logic [DW-1:0] d_cd, d_ld;

    task automatic model_reset();
        m_last_core = 1'b0;
        m_locked    = 1'b0;
        m_force     = 1'b0;
        m_streak    = 0;
        e_en        = 1'b0;
        rq.delete();
        d_cv = 1'b0;
        d_lv = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(3) == 0) a = '1;
        else a = AW'($urandom_range(15));
        return a;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit cv, input bit crw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld, input bit lk,
                        output bit gc, output bit gl);
        bit   ok_c, ok_l;
        rsp_t r;
        core_req_valid = cv;  core_req_rw = crw;  core_req_addr = ca;  core_req_wdata = cd;
        ld_req_valid   = lv;  ld_req_addr = la;   ld_req_wdata = ld;   ld_lock = lk;
        #1;
        if (m_force)                begin ok_c = 1'b1; ok_l = 1'b0; end
        else if (m_locked && lk)    begin ok_c = 1'b0; ok_l = 1'b1; end
        else                        begin ok_c = 1'b1; ok_l = 1'b1; end
        ok_c = ok_c && cv;
        ok_l = ok_l && lv;
        gc = ok_c && (!ok_l || !m_last_core);
        gl = ok_l && !gc;
        chk("core_ready", core_req_ready, gc);
        chk("ld_ready", ld_req_ready, gl);
        chk("mem_en", mem_en, e_en);
        if (e_en) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", core_rsp_valid, 1);
            chk("rsp_rdata", core_rsp_rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            chk("rsp_valid", core_rsp_valid, 0);
        end
        // The access issued last cycle completes at the coming edge.
        if (e_en) begin
            if (e_we) shadow[e_addr] = e_wd;
            else      rq[rq.size()-1].data = shadow[e_addr];
        end
        if (m_force) begin
            m_force  = 1'b0;
            m_locked = gc && lk;
            if (gc) m_streak = 0;
        end else if (m_locked && lk) begin
            if (m_streak == MAX_LOCK && cv) m_force = 1'b1;
            if (gl && m_streak < MAX_LOCK) m_streak++;
        end else begin
            m_locked = gl && lk;
            if (m_locked) m_streak = 1;
        end
        if (gc || gl) m_last_core = gc;
        e_en   = gc || gl;
        e_we   = gc ? crw : 1'b1;
        e_addr = gc ? ca : la;
        e_wd   = gc ? cd : ld;
        if (gc) begin
            r.due  = cyc + 2;
            r.data = '0;
            rq.push_back(r);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit gc, gl;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0, gc, gl);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            core_req_valid = 1'($urandom);  core_req_rw  = 1'($urandom);
            core_req_addr  = AW'($urandom); core_req_wdata = $urandom;
            ld_req_valid   = 1'($urandom);  ld_req_addr  = AW'($urandom);
            ld_req_wdata   = $urandom;      ld_lock      = 1'($urandom);
            #1;
            chk("rst_ctl", {core_req_ready, ld_req_ready, core_rsp_valid, mem_en, mem_we, mem_addr}, 0);
            chk("rst_rdata", core_rsp_rdata, 0);
            chk("rst_wdata", mem_wdata, 0);
            @(negedge clk);
        end
        model_reset();
        reset = 1'b0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic rand_phase(input int n, input int pc, input int pl, input int plk);
        bit gc, gl, lk;
        for (int i = 0; i < n; i++) begin
            if (!d_cv && $urandom_range(99) < pc) begin
                d_cv = 1'b1; d_crw = 1'($urandom); d_ca = rand_addr(); d_cd = $urandom;
            end
            if (!d_lv && $urandom_range(99) < pl) begin
                d_lv = 1'b1; d_la = rand_addr(); d_ld = $urandom;
            end
            lk = ($urandom_range(99) < plk);
            step(d_cv, d_crw, d_ca, d_cd, d_lv, d_la, d_ld, lk, gc, gl);
            if (gc) d_cv = 1'b0;
            if (gl) d_lv = 1'b0;
        end
    endtask

    initial begin
        bit gc, gl;
        reset = 1'b1;
        core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_addr = '0; core_req_wdata = '0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_wdata = '0; ld_lock = 1'b0;
        model_reset();
        @(negedge clk);
        poke(9'h010, 32'hDEADBEEF);
        do_reset(4);

        // Core read with a known value; then core write colliding with a loader write.
        step(1, 0, 9'h010, '0, 0, '0, '0, 0, gc, gl);
        step(1, 1, 9'h1FF, 32'h12345678, 1, 9'h000, 32'hA5A5A5A5, 0, gc, gl);
        step(1, 1, 9'h1FF, 32'h12345678, 0, '0, '0, 0, gc, gl);
        idle(3);
        step(1, 0, 9'h1FF, '0, 1, 9'h000, 32'h0, 0, gc, gl);
        step(1, 0, 9'h1FF, '0, 0, '0, '0, 0, gc, gl);
        idle(3);

        // Read accepted, then reset pulsed before the response is due.
        step(1, 0, 9'h010, '0, 0, '0, '0, 0, gc, gl);
        do_reset(1);
        idle(4);

        // First tie after reset goes to the core.
        rand_phase(1, 100, 100, 0);
        rand_phase(16, 100, 100, 0);
        rand_phase(30, 100, 100, 100);
        rand_phase(10, 100, 100, 0);
        rand_phase(20, 100, 40, 100);
        rand_phase(400, 60, 60, 70);
        rand_phase(200, 30, 90, 90);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
